onewire_seq: RTL and testbench



---
 rtl/onewire_seq.sv | 206 ++++++++++++++++++++
 tb/tb_onewire_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onewire_seq.sv
// onewire_seq: byte-level command sequencer for the onewire bit master.
// Expands reset/write/read commands into polled Avalon slot writes and returns one response each.
module onewire_seq #(
  parameter int unsigned POLL = 8,
  parameter int unsigned TMO  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_ovd,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_presence,
  output logic        rsp_error,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);
  localparam int unsigned PW = $clog2(POLL + 1);
  localparam int unsigned TW = $clog2(TMO + 1);
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WAIT, S_RD, S_RSP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic          ovd_q, ovd_d;
  logic [7:0]    sh_q, sh_d;
  logic [3:0]    bits_q, bits_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_presence_q, rsp_presence_d;
  logic          rsp_error_q, rsp_error_d;
  logic          avm_read_q, avm_read_d;
  logic          avm_write_q, avm_write_d;
  logic [31:0]   avm_writedata_q, avm_writedata_d;
  logic [TW-1:0] tmo_inc_c;
  logic          unused_rdata_c;

  // Slot control word: bit0 overdrive, bit1 reset slot, bit2 data bit (1 also means read slot).
  function automatic logic [31:0] slot_word(input logic [1:0] op, input logic ovd, input logic lsb);
    logic rst_slot;
    logic dbit;
    rst_slot = (op != OP_WR) && (op != OP_RD);
    dbit     = (op == OP_WR) ? lsb : (op == OP_RD);
    return {29'd0, dbit, rst_slot, ovd};
  endfunction

  assign unused_rdata_c = ^{avm_readdata[31:5], avm_readdata[3], avm_readdata[1:0]};

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    ovd_d           = ovd_q;
    sh_d            = sh_q;
    bits_d          = bits_q;
    poll_d          = poll_q;
    tmo_d           = tmo_q;
    cmd_ready_d     = cmd_ready_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_data_d      = rsp_data_q;
    rsp_presence_d  = rsp_presence_q;
    rsp_error_d     = rsp_error_q;
    avm_read_d      = avm_read_q;
    avm_write_d     = avm_write_q;
    avm_writedata_d = avm_writedata_q;
    tmo_inc_c       = tmo_q + TW'(1);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d            = cmd_op;
          ovd_d           = cmd_ovd;
          sh_d            = (cmd_op == OP_WR) ? cmd_data : 8'd0;
          bits_d          = (cmd_op == OP_WR || cmd_op == OP_RD) ? 4'd8 : 4'd1;
          tmo_d           = '0;
          rsp_data_d      = 8'd0;
          rsp_presence_d  = 1'b0;
          rsp_error_d     = 1'b0;
          cmd_ready_d     = 1'b0;
          avm_write_d     = 1'b1;
          avm_writedata_d = slot_word(cmd_op, cmd_ovd, cmd_data[0]);
          state_d         = S_WR;
        end
      end
      S_WR: begin
        if (!avm_waitrequest) begin
          avm_write_d     = 1'b0;
          avm_writedata_d = 32'd0;
          poll_d          = PW'(POLL);
          state_d         = S_WAIT;
        end
      end
      S_WAIT: begin
        poll_d = poll_q - PW'(1);
        if (poll_q == PW'(1)) begin
          avm_read_d = 1'b1;
          state_d    = S_RD;
        end
      end
      S_RD: begin
        if (!avm_waitrequest) begin
          avm_read_d = 1'b0;
          if (!avm_readdata[4]) begin
            tmo_d = tmo_inc_c;
            if (tmo_inc_c == TW'(TMO)) begin
              rsp_error_d = 1'b1;
              rsp_data_d  = 8'd0;
              rsp_valid_d = 1'b1;
              state_d     = S_RSP;
            end else begin
              poll_d  = PW'(POLL);
              state_d = S_WAIT;
            end
          end else begin
            tmo_d  = '0;
            bits_d = bits_q - 4'd1;
            case (op_q)
              OP_WR:   sh_d = {1'b0, sh_q[7:1]};
              OP_RD:   sh_d = {avm_readdata[2], sh_q[7:1]};
              default: rsp_presence_d = ~avm_readdata[2];
            endcase
            if (bits_q == 4'd1) begin
              rsp_data_d  = (op_q == OP_RD) ? sh_d : 8'd0;
              rsp_valid_d = 1'b1;
              state_d     = S_RSP;
            end else begin
              avm_write_d     = 1'b1;
              avm_writedata_d = slot_word(op_q, ovd_q, sh_d[0]);
              state_d         = S_WR;
            end
          end
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        avm_read_d  = 1'b0;
        avm_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      op_q            <= 2'd0;
      ovd_q           <= 1'b0;
      sh_q            <= 8'd0;
      bits_q          <= 4'd0;
      poll_q          <= '0;
      tmo_q           <= '0;
      cmd_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_data_q      <= 8'd0;
      rsp_presence_q  <= 1'b0;
      rsp_error_q     <= 1'b0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      ovd_q           <= ovd_d;
      sh_q            <= sh_d;
      bits_q          <= bits_d;
      poll_q          <= poll_d;
      tmo_q           <= tmo_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_data_q      <= rsp_data_d;
      rsp_presence_q  <= rsp_presence_d;
      rsp_error_q     <= rsp_error_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_writedata_q <= avm_writedata_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_presence  = rsp_presence_q;
  assign rsp_error     = rsp_error_q;
  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_writedata = avm_writedata_q;
endmodule

// File: tb/tb_onewire_seq.sv
// tb_onewire_seq: vector table plus corner sequences for onewire_seq against a stubbed bit master.
module tb_onewire_seq;
  localparam int POLL = 8;
  localparam int TMO  = 4;
  localparam int NV   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_ovd;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic        rsp_valid, rsp_ready, rsp_presence, rsp_error;
  logic [7:0]  rsp_data;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_waitrequest = 1'b0;

  onewire_seq #(.POLL(POLL), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_ovd(cmd_ovd), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_presence(rsp_presence), .rsp_error(rsp_error),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] op;
    logic       ovd;
    logic [7:0] data;
    logic       present;
    logic [7:0] line;     // line level sampled in slot i appears at bit i
    int         polls;    // reads until completion per slot, 0 = never completes
    logic       stall;    // random waitrequest
    logic [7:0] exp_data;
    logic       exp_pres;
    logic       exp_err;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Stub configuration, written by the main thread only.
  int         epoch = 0;
  bit         rand_wait = 1'b0;
  int         stub_polls = 1;
  logic [7:0] stub_line = 8'd0;
  // Stub observations, written by the stub process only.
  int          seen_epoch = 0;
  logic [31:0] wq[$];
  int          rcount = 0;
  int          slot_idx = -1;
  int          slot_reads = 0;
  int          proto_viol = 0;
  bit          prev_stall = 1'b0;
  logic [33:0] prev_req = 34'd0;

  // Bit-master stub: drives waitrequest/readdata for the next edge and logs completed transfers.
  always @(negedge clk) begin
    logic        w;
    logic [31:0] rd;
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      wq.delete();
      rcount     = 0;
      slot_idx   = -1;
      slot_reads = 0;
    end
    if (avm_read && avm_write) proto_viol++;
    if (prev_stall && ({avm_read, avm_write, avm_writedata} != prev_req)) proto_viol++;
    w     = rand_wait && ($urandom_range(0, 2) == 0);
    rd    = $urandom;
    rd[4] = (stub_polls != 0) && (slot_reads + 1 >= stub_polls);
    rd[2] = (slot_idx >= 0 && slot_idx < 8) ? stub_line[3'(slot_idx)] : 1'b1;
    avm_waitrequest = w;
    avm_readdata    = rd;
    if (avm_write && !w) begin
      wq.push_back(avm_writedata);
      slot_idx++;
      slot_reads = 0;
    end
    if (avm_read && !w) begin
      rcount++;
      slot_reads++;
    end
    prev_stall = (avm_read || avm_write) && w && !rst;
    prev_req   = {avm_read, avm_write, avm_writedata};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: what a command should do on the wire and in its response.
  function automatic bit is_rst_op(input logic [1:0] op);
    return (op == 2'd0) || (op == 2'd3);
  endfunction
  function automatic int ref_slots(input vec_t v);
    if (v.polls == 0) return 1;
    return is_rst_op(v.op) ? 1 : 8;
  endfunction
  function automatic int ref_reads(input vec_t v);
    if (v.polls == 0) return TMO;
    return ref_slots(v) * v.polls;
  endfunction
  function automatic int ref_cycles(input vec_t v);
    return 1 + ref_slots(v) * (POLL + 2) + (ref_reads(v) - ref_slots(v)) * (POLL + 1);
  endfunction
  function automatic logic [31:0] ref_word(input vec_t v, input int i);
    int b;
    b = (v.op == 2'd1) ? int'(v.data[i]) : ((v.op == 2'd2) ? 1 : 0);
    return 32'(v.ovd) + (is_rst_op(v.op) ? 32'd2 : 32'd0) + 32'(b * 4);
  endfunction
  function automatic vec_t with_ref(input vec_t v);
    vec_t r;
    r          = v;
    r.exp_err  = (v.polls == 0);
    r.exp_data = (!r.exp_err && v.op == 2'd2) ? v.line : 8'd0;
    r.exp_pres = !r.exp_err && is_rst_op(v.op) && v.present;
    return r;
  endfunction
  function automatic vec_t mk(input logic [1:0] op, input logic ovd, input logic [7:0] data,
                              input logic present, input logic [7:0] line, input int polls,
                              input logic stall, input logic [7:0] ed, input logic ep, input logic ee);
    vec_t v;
    v.op = op; v.ovd = ovd; v.data = data; v.present = present; v.line = line;
    v.polls = polls; v.stall = stall; v.exp_data = ed; v.exp_pres = ep; v.exp_err = ee;
    return v;
  endfunction

  task automatic setup_stub(input vec_t v);
    epoch++;
    rand_wait  = v.stall;
    stub_polls = v.polls;
    stub_line  = is_rst_op(v.op) ? {7'd0, ~v.present} : v.line;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int t0, tr, nw;
    bit got;
    setup_stub(v);
    chk({nm, "_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_ovd = v.ovd; cmd_data = v.data;
    t0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    got = 1'b0;
    tr  = 0;
    for (int k = 0; k < 4000; k++) begin
      if (rsp_valid) begin got = 1'b1; tr = cyc; break; end
      @(negedge clk);
    end
    chk({nm, "_rsp_seen"}, 32'(got), 32'd1);
    chk({nm, "_rsp"}, {21'd0, rsp_data, rsp_presence, rsp_error, 1'b0},
        {21'd0, v.exp_data, v.exp_pres, v.exp_err, 1'b0});
    nw = wq.size();
    chk({nm, "_nwrites"}, 32'(nw), 32'(ref_slots(v)));
    for (int i = 0; i < nw && i < 8; i++) chk($sformatf("%s_wdata%0d", nm, i), wq[i], ref_word(v, i));
    chk({nm, "_nreads"}, 32'(rcount), 32'(ref_reads(v)));
    if (!v.stall) chk({nm, "_latency"}, 32'(tr - t0), 32'(ref_cycles(v)));
    @(negedge clk);
    chk({nm, "_ready_back"}, {30'd0, rsp_valid, cmd_ready}, 32'd1);
    chk({nm, "_protocol"}, 32'(proto_viol), 32'd0);
  endtask

  vec_t tbl[NV];
  logic [31:0] wa5[8];

  initial begin
    int  t0;
    bit  found;
    vec_t v;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_ovd = 1'b0; cmd_data = 8'd0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", {rsp_data, cmd_ready, rsp_valid, rsp_presence, rsp_error, avm_read, avm_write},
        {8'd0, 6'b100000});
    chk("reset_wdata", avm_writedata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    tbl[0] = mk(2'd0, 1'b0, 8'h00, 1'b1, 8'h00, 1, 1'b0, 8'h00, 1'b1, 1'b0);
    tbl[1] = mk(2'd1, 1'b1, 8'hA5, 1'b0, 8'h00, 1, 1'b0, 8'h00, 1'b0, 1'b0);
    tbl[2] = mk(2'd2, 1'b0, 8'h00, 1'b0, 8'h4D, 1, 1'b0, 8'h4D, 1'b0, 1'b0);
    tbl[3] = mk(2'd3, 1'b1, 8'h00, 1'b0, 8'h00, 1, 1'b0, 8'h00, 1'b0, 1'b0);
    tbl[4] = mk(2'd2, 1'b0, 8'h00, 1'b0, 8'hB2, 3, 1'b0, 8'hB2, 1'b0, 1'b0);
    tbl[5] = mk(2'd2, 1'b0, 8'h00, 1'b0, 8'hFF, 0, 1'b0, 8'h00, 1'b0, 1'b1);
    tbl[6] = mk(2'd1, 1'b0, 8'h5A, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b1);
    tbl[7] = mk(2'd0, 1'b0, 8'h00, 1'b1, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b1);
    tbl[8] = mk(2'd0, 1'b0, 8'h00, 1'b1, 8'h00, 2, 1'b0, 8'h00, 1'b1, 1'b0);
    tbl[9] = mk(2'd2, 1'b1, 8'h00, 1'b0, 8'h96, 3, 1'b1, 8'h96, 1'b0, 1'b0);
    for (int i = 10; i < NV; i++)
      tbl[i] = with_ref(mk(2'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), 1'($urandom),
                           8'($urandom), $urandom_range(1, 3), 1'($urandom), 8'd0, 1'b0, 1'b0));
    for (int i = 0; i < NV; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Write 0xA5 overdrive: literal slot word sequence.
    wa5[0] = 32'h5; wa5[1] = 32'h1; wa5[2] = 32'h5; wa5[3] = 32'h1;
    wa5[4] = 32'h1; wa5[5] = 32'h5; wa5[6] = 32'h1; wa5[7] = 32'h5;
    run_vec(tbl[1], "a5");
    for (int i = 0; i < 8 && i < wq.size(); i++) chk($sformatf("a5_word%0d", i), wq[i], wa5[i]);

    // Reset during the wait of bit 3 of a write.
    v = mk(2'd1, 1'b0, 8'h3C, 1'b0, 8'h00, 1, 1'b0, 8'h00, 1'b0, 1'b0);
    setup_stub(v);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_ovd = v.ovd; cmd_data = v.data;
    @(negedge clk);
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (wq.size() == 4 && !avm_write && !avm_read) begin found = 1'b1; break; end
    end
    chk("rst_reached_bit3_wait", 32'(found), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_immediate", {29'd0, avm_read, avm_write, cmd_ready}, 32'd1);
    @(negedge clk);
    chk("rst_held", {avm_writedata[29:0], avm_read, avm_write}, 32'd0);
    chk("rst_held_ready", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    rst = 1'b0;
    chk("rst_no_more_writes", 32'(wq.size()), 32'd4);

    // Reset command with cmd_valid held and response back-pressured.
    v = mk(2'd0, 1'b0, 8'h00, 1'b1, 8'h00, 1, 1'b0, 8'h00, 1'b1, 1'b0);
    setup_stub(v);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_ovd = 1'b0; cmd_data = 8'hFF;
    t0 = cyc;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rsp_valid) begin found = 1'b1; break; end
    end
    chk("hold_rsp_seen", 32'(found), 32'd1);
    chk("hold_latency", 32'(cyc - t0), 32'(POLL + 3));
    chk("hold_rsp", {29'd0, rsp_presence, rsp_error, 1'b0}, 32'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold_stall%0d", k), {28'd0, rsp_valid, cmd_ready, avm_read, avm_write}, 32'h8);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("hold_release", {30'd0, rsp_valid, cmd_ready}, 32'd1);
    chk("hold_single_write", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) chk("hold_write_word", wq[0], 32'h2);
    chk("final_protocol", 32'(proto_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
